// File: rtl/lcd_text_console.sv
// lcd_text_console
//   Character-cell text console: a 4-row x 16-column (64 x 8) text buffer
//   fed by a byte stream. Printable bytes are written at the cursor. A small
//   set of control bytes is interpreted: CR, LF, BS and FF. Any other
//   control byte is swallowed. Reaching the end of the screen either scrolls
//   the buffer up one row or wraps the cursor to address 0.
//
// Parameters
//   BLANK_CHAR  fill byte used by clear, scroll and backspace
//   SCROLL_EN   1: scroll up at the bottom of the screen; 0: wrap to address 0
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   in_valid  upstream byte valid
//   in_data   upstream character / control byte
//   in_ready  high when a byte can be accepted this cycle
//   rd_addr   display-side read address (row*16 + col)
//   rd_data   display-side read data, combinational from rd_addr
//   cursor    next write address
//   busy      clear or scroll sweep in progress

module lcd_text_console #(
    parameter logic [7:0]  BLANK_CHAR = 8'h20,
    parameter int unsigned SCROLL_EN  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [5:0] cursor,
    output logic       busy
);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        CLEAR        = 2'd0,
        IDLE         = 2'd1,
        SCROLL_COPY  = 2'd2,
        SCROLL_BLANK = 2'd3
    } state_t;

    state_t     state;
    logic [5:0] sweep;
    logic       armed;

    logic [7:0] mem [64];

    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;

    logic [1:0] row;
    logic [3:0] col;
    logic       printable;
    logic       at_end;

    assign row       = cursor[5:4];
    assign col       = cursor[3:0];
    assign printable = (in_data[7:5] != 3'b000);
    assign at_end    = (cursor == 6'd63);

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Old cell contents stay visible until the write edge.
    assign rd_data = mem[rd_addr];

    // Single write port shared by the sweeps and the byte stream.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = BLANK_CHAR;
        case (state)
            CLEAR: begin
                if (armed) begin
                    wr_en   = 1'b1;
                    wr_addr = sweep;
                end
            end
            SCROLL_COPY: begin
                wr_en   = 1'b1;
                wr_addr = sweep;
                wr_data = mem[sweep + 6'd16];
            end
            SCROLL_BLANK: begin
                wr_en   = 1'b1;
                wr_addr = sweep;
            end
            IDLE: begin
                if (in_valid) begin
                    if (printable) begin
                        wr_en   = 1'b1;
                        wr_addr = cursor;
                        wr_data = in_data;
                    end else if (in_data == CH_BS && col != 4'd0) begin
                        wr_en   = 1'b1;
                        wr_addr = cursor - 6'd1;
                    end
                end
            end
        endcase
    end

    // Buffer has no reset; its contents are meaningless until CLEAR completes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // armed spends the first edge after reset release idle, so the clear
    // sweep starts from a clean, synchronous point; afterwards it stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CLEAR;
            sweep  <= '0;
            cursor <= '0;
            armed  <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                CLEAR: begin
                    if (armed) begin
                        if (sweep == 6'd63) begin
                            state  <= IDLE;
                            cursor <= '0;
                        end else begin
                            sweep <= sweep + 6'd1;
                        end
                    end
                end

                IDLE: begin
                    if (in_valid) begin
                        if (printable) begin
                            if (!at_end) begin
                                cursor <= cursor + 6'd1;
                            end else if (SCROLL_EN != 0) begin
                                state  <= SCROLL_COPY;
                                sweep  <= '0;
                                cursor <= 6'd48;
                            end else begin
                                cursor <= '0;
                            end
                        end else begin
                            case (in_data)
                                CH_CR: cursor <= {row, 4'd0};
                                CH_LF: begin
                                    if (row != 2'd3) begin
                                        cursor <= {row + 2'd1, 4'd0};
                                    end else if (SCROLL_EN != 0) begin
                                        state  <= SCROLL_COPY;
                                        sweep  <= '0;
                                        cursor <= 6'd48;
                                    end else begin
                                        cursor <= '0;
                                    end
                                end
                                CH_BS: begin
                                    if (col != 4'd0) begin
                                        cursor <= cursor - 6'd1;
                                    end
                                end
                                CH_FF: begin
                                    state  <= CLEAR;
                                    sweep  <= '0;
                                    cursor <= '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                SCROLL_COPY: begin
                    if (sweep == 6'd47) begin
                        state <= SCROLL_BLANK;
                        sweep <= 6'd48;
                    end else begin
                        sweep <= sweep + 6'd1;
                    end
                end

                SCROLL_BLANK: begin
                    // Sweep holds at 63 on exit rather than wrapping.
                    if (sweep == 6'd63) begin
                        state <= IDLE;
                    end else begin
                        sweep <= sweep + 6'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/lcd_text_console.md
LCD_TEXT_CONSOLE -- requirements
Module: lcd_text_console

Interface
REQ-001 Parameter BLANK_CHAR, default 8'h20: fill byte used by clear, scroll and backspace.
REQ-002 Parameter SCROLL_EN, default 1: 1 = scroll up at the bottom of the screen; 0 = wrap the cursor to address 0.
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream byte valid.
REQ-006 in_data  input  8  upstream character or control byte.
REQ-007 in_ready  output  1  block can accept a byte this cycle.
REQ-008 rd_addr  input  6  display-side read address (row*16 + col).
REQ-009 rd_data  output  8  display-side read data.
REQ-010 cursor  output  6  next write address.
REQ-011 busy  output  1  clear or scroll in progress.

Function
REQ-012 The block SHALL hold a 64x8 text buffer organised as 4 rows of 16 columns, with address = row*16 + col.
REQ-013 rd_data SHALL equal buf[rd_addr] combinationally (zero latency).
REQ-014 When a read and a write hit the same address in one cycle, rd_data SHALL show the old value until the edge.
REQ-015 The FSM SHALL have four states: CLEAR, IDLE, SCROLL_COPY, SCROLL_BLANK.
REQ-016 busy SHALL equal (state != IDLE), and in_ready SHALL equal (state == IDLE).
REQ-017 A byte SHALL be accepted only on a rising edge with in_valid && in_ready; in_data is sampled on that edge, and one byte is accepted per cycle at most.
REQ-018 A byte seen while in_ready = 0 SHALL be neither consumed nor lost; upstream holds it.
REQ-019 CLEAR SHALL write BLANK_CHAR to addresses 0..63, one address per cycle, for 64 cycles, then go to IDLE with cursor = 0.
REQ-020 Printable bytes are every value except 0x00-0x1F. A printable byte SHALL be written to buf[cursor] on the accept edge, and cursor SHALL become cursor+1.
REQ-021 Column 15 of rows 0-2 SHALL roll to column 0 of the next row through plain +1.
REQ-022 A printable byte at cursor 63 with SCROLL_EN = 1 SHALL be written, then the FSM enters SCROLL_COPY and cursor becomes 48.
REQ-023 A printable byte at cursor 63 with SCROLL_EN = 0 SHALL be written, then cursor becomes 0 and the FSM stays in IDLE.
REQ-024 0x0D (CR) SHALL set the cursor column to 0 and keep the row.
REQ-025 0x0A (LF) on rows 0-2 SHALL set cursor = (row+1)*16.
REQ-026 0x0A (LF) on row 3 SHALL enter SCROLL_COPY with cursor 48 when SCROLL_EN = 1, or set cursor to 0 when SCROLL_EN = 0.
REQ-027 0x08 (BS) with column > 0 SHALL decrement cursor and write BLANK_CHAR to the new cursor address; BS at column 0 SHALL have no effect.
REQ-028 0x0C (FF) SHALL enter CLEAR, starting at address 0, with cursor 0.
REQ-029 Any other byte in 0x00-0x1F SHALL be accepted and discarded, with no change to the buffer or cursor.
REQ-030 SCROLL_COPY SHALL perform buf[i] <= buf[i+16] for i = 0..47, one per cycle, taking 48 cycles.
REQ-031 SCROLL_BLANK SHALL perform buf[i] <= BLANK_CHAR for i = 48..63, taking 16 cycles, then go to IDLE.
REQ-032 The total scroll time SHALL be 64 cycles with in_ready = 0 throughout.
REQ-033 Display reads during a scroll or clear SHALL be permitted; transient mixed content is acceptable.
REQ-034 The internal 6-bit sweep counter SHALL stop at its terminal value and never wrap into a second pass.

Reset
REQ-035 Asserting rst_n low SHALL immediately force: state = CLEAR, sweep counter = 0, cursor = 0, busy = 1, in_ready = 0.
REQ-036 Buffer contents SHALL be undefined while rst_n is low.
REQ-037 After rst_n deasserts, the CLEAR sweep SHALL run 64 cycles, then in_ready = 1.
REQ-038 Reset asserted mid-scroll or mid-clear SHALL abort the sweep and restart CLEAR from address 0 after release.

Verification
REQ-039 Reset release, idle in_valid -> in_ready rises on the 65th edge after release; all 64 rd_data reads return 0x20; cursor = 0.
REQ-040 Stream "HELLO" -> buf[0..4] = 48 45 4C 4C 4F and cursor = 5; then CR, LF, "A" -> buf[16] = 0x41 and cursor = 17.
REQ-041 Fill 64 printable bytes 0x40+i (SCROLL_EN = 1) -> the 64th accept is followed by in_ready low for exactly 64 cycles; afterwards buf[0..47] = old buf[16..63], buf[48..63] = 0x20, cursor = 48.
REQ-042 With SCROLL_EN = 0, write 64 bytes, then "Z" -> buf[0] = 0x5A, cursor = 1, in_ready never drops.
REQ-043 Cursor 0x13, send BS -> cursor = 0x12 and buf[0x12] = 0x20; send BS at cursor 0x10 -> no change.
REQ-044 Assert rst_n at SCROLL_COPY cycle 20, release 3 cycles later -> busy = 1 immediately; the full 64-cycle clear runs; all cells read 0x20.
